// File: rtl/usb_fs_pkg.sv
// Shared constants and encodings for the full-speed USB transmit path.
package usb_fs_pkg;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;

  // SYNC goes out LSB first: seven 0s then a 1
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  typedef enum logic [2:0] {
    TX_IDLE, TX_SYNC, TX_PID, TX_DATA, TX_CRC, TX_EOP, TX_EOP_J
  } tx_state_e;

  // {dp, dn}
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10
  } line_state_e;

  function automatic logic is_data_pid(input logic [3:0] p);
    return p[1:0] == 2'b11;
  endfunction
endpackage

// File: rtl/usb_fs_crc16.sv
// Serial CRC16 (poly 0x8005), one data bit per enable; MSB of the register is the first bit on the wire.
module usb_fs_crc16 import usb_fs_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic [15:0] crc_nxt;

  always_comb begin
    crc_nxt = {crc[14:0], 1'b0};
    if (crc[15] ^ din) crc_nxt = crc_nxt ^ CRC16_POLY;
  end

  always_ff @(posedge clk) begin
    if (!reset)     crc <= CRC16_PRESET;
    else if (clear) crc <= CRC16_PRESET;
    else if (en)    crc <= crc_nxt;
  end
endmodule

// File: rtl/usb_fs_tx_serializer.sv
// Full-speed USB packet transmitter: SYNC, PID, payload, CRC16, EOP with bit stuffing and NRZI.
module usb_fs_tx_serializer import usb_fs_pkg::*; #(
  parameter int CLK_DIV      = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_start,
  input  logic [3:0] pid,
  input  logic       tx_data_avail,
  output logic       tx_data_get,
  input  logic [7:0] tx_data,
  output logic       pkt_end,
  output logic       busy,
  output logic       oe,
  output logic       dp,
  output logic       dn
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int EOP_W = (EOP_SE0_BITS > 0) ? $clog2(EOP_SE0_BITS + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [EOP_W-1:0] EOP_LAST = EOP_W'(EOP_SE0_BITS);

  tx_state_e        state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [2:0]       stuff_cnt;
  logic [3:0]       crc_cnt;
  logic [EOP_W-1:0] eop_cnt;
  logic [7:0]       shreg;
  logic [3:0]       pid_r;
  logic             data_pkt;
  logic [15:0]      crc;

  logic accept, tick, in_field, stuff_now, boundary, take_byte;
  logic field_bit, crc_en, crc_clear;

  assign accept    = pkt_start && !busy;
  assign tick      = (div_cnt == DIV_LAST) && (state != TX_IDLE);
  assign in_field  = state inside {TX_SYNC, TX_PID, TX_DATA, TX_CRC};
  // a stuff bit still owed when entering EOP goes out before the SE0
  assign stuff_now = (stuff_cnt == 3'd6) && (in_field || state == TX_EOP);
  assign boundary  = (state == TX_DATA) && (bit_cnt == 3'd0);
  assign take_byte = tick && !stuff_now && boundary && tx_data_avail;
  assign tx_data_get = take_byte && reset;
  assign crc_en    = tick && !stuff_now && (state == TX_DATA) && (take_byte || !boundary);
  assign crc_clear = tick && !stuff_now && (state == TX_PID) && (bit_cnt == 3'd7);

  // Next logical bit of the current field; an empty byte slot rolls straight into CRC bit 0.
  always_comb begin
    field_bit = shreg[0];
    case (state)
      TX_DATA: if (boundary) field_bit = tx_data_avail ? tx_data[0] : ~crc[~crc_cnt];
      TX_CRC:  field_bit = ~crc[~crc_cnt];
      default: ;
    endcase
  end

  usb_fs_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (field_bit),
    .crc   (crc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= TX_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= 3'd0;
      stuff_cnt <= 3'd0;
      crc_cnt   <= 4'd0;
      eop_cnt   <= '0;
      shreg     <= 8'd0;
      pid_r     <= 4'd0;
      data_pkt  <= 1'b0;
      busy      <= 1'b0;
      pkt_end   <= 1'b0;
      oe        <= 1'b0;
      {dp, dn}  <= LINE_J;
    end else begin
      pkt_end <= 1'b0;
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (pkt_end) busy <= 1'b0;
      if (accept) begin
        div_cnt   <= '0;
        state     <= TX_SYNC;
        busy      <= 1'b1;
        bit_cnt   <= 3'd0;
        stuff_cnt <= 3'd0;
        shreg     <= SYNC_PATTERN;
        pid_r     <= pid;
        data_pkt  <= is_data_pid(pid);
      end else if (tick) begin
        oe <= 1'b1;
        if (stuff_now) begin
          stuff_cnt <= 3'd0;
          dp <= ~dp;
          dn <= ~dn;
        end else begin
          if (in_field) begin
            stuff_cnt <= field_bit ? stuff_cnt + 3'd1 : 3'd0;
            if (!field_bit) begin
              dp <= ~dp;
              dn <= ~dn;
            end
          end
          case (state)
            TX_SYNC: begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= TX_PID;
                shreg <= {~pid_r, pid_r};
              end
            end
            TX_PID: begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                crc_cnt <= 4'd0;
                eop_cnt <= '0;
                state   <= data_pkt ? TX_DATA : TX_EOP;
              end
            end
            TX_DATA: begin
              if (boundary && !tx_data_avail) begin
                state   <= TX_CRC;
                crc_cnt <= 4'd1;
              end else begin
                shreg   <= boundary ? {1'b0, tx_data[7:1]} : shreg >> 1;
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            TX_CRC: begin
              crc_cnt <= crc_cnt + 4'd1;
              if (crc_cnt == 4'd15) begin
                state   <= TX_EOP;
                eop_cnt <= '0;
              end
            end
            TX_EOP: begin
              if (eop_cnt == EOP_LAST) begin
                {dp, dn} <= LINE_J;
                state    <= TX_EOP_J;
              end else begin
                {dp, dn} <= LINE_SE0;
                eop_cnt  <= eop_cnt + 1'b1;
              end
            end
            TX_EOP_J: begin
              oe       <= 1'b0;
              {dp, dn} <= LINE_J;
              pkt_end  <= 1'b1;
              state    <= TX_IDLE;
            end
            default: state <= TX_IDLE;
          endcase
        end
      end
    end
  end
endmodule
